uart_spi_bridge: RTL
====================

UART_SPI_BRIDGE -- requirements
Module: uart_spi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning SPI address field width in bits (1..16).
REQ-002 SHALL have parameter DATA_W, default 8, meaning SPI data field width in bits (1..16).
REQ-003 SHALL have parameter SCLK_DIV, default 4, meaning i_clock cycles per SCLK half-period (>=1).
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 500000, meaning inter-byte timeout in i_clock cycles.
REQ-005 SHALL have port i_clock, input, 1, the single clock for all logic.
REQ-006 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports i_rx_dv (input, 1, one-cycle received-byte strobe) and i_rx_byte (input, 8, received byte).
REQ-008 SHALL have ports o_tx_dv (output, 1, one-cycle transmit strobe), o_tx_byte (output, 8, byte to send) and i_tx_active (input, 1, UART transmitter busy).
REQ-009 SHALL have ports o_spi_cs_n, o_spi_sclk, o_spi_mosi (outputs, 1 each) and i_spi_miso (input, 1).
REQ-010 SHALL have ports o_busy (output, 1, high outside IDLE) and o_err (output, 1, one-cycle error pulse).

Function
REQ-011 SHALL parse frames: opcode byte, then AB=ceil(ADDR_W/8) address bytes MSB first; a write also carries DB=ceil(DATA_W/8) data bytes MSB first.
REQ-012 SHALL use opcode 0x57 for write and 0x52 for read.
REQ-013 SHALL use the states IDLE -> GET_ADDR -> (GET_DATA on write) -> SPI_RUN -> SEND_RESP -> IDLE.
REQ-014 SHALL right-align multi-byte fields and drop unused upper bits.
REQ-015 SHALL, for an unknown opcode in IDLE, send 0x15 (NAK), pulse o_err and return to IDLE.
REQ-016 SPI_RUN SHALL use SPI mode 0: cs_n low for one half-period before the first rising SCLK edge, and ADDR_W+DATA_W bits shifted MSB first.
REQ-017 SHALL change MOSI on falling SCLK edges, sample MISO on rising SCLK edges, and hold cs_n low one half-period after the last edge before raising it.
REQ-018 SHALL drive the data field of a read as zeros on MOSI; the last DATA_W sampled bits SHALL form the read value.
REQ-019 SEND_RESP SHALL send 0x06 (ACK) after a write, or DB bytes of the read value MSB first after a read.
REQ-020 SHALL pulse o_tx_dv only when i_tx_active is low, hold o_tx_byte stable until the next pulse, and skip one cycle after each pulse before sampling i_tx_active again.
REQ-021 SHALL ignore any i_rx_dv in SPI_RUN or SEND_RESP and pulse o_err for it.
REQ-022 SHALL start a new frame no earlier than the cycle after the last response byte's o_tx_dv.

Reset
REQ-023 i_reset SHALL, on the next clock edge in any state (including mid-SPI or mid-response), force IDLE, cs_n=1, sclk=0, mosi=0, o_tx_dv=0, o_tx_byte=0, o_busy=0, o_err=0, and clear all counters.

Configuration
REQ-024 With UART_SPI_BRIDGE_TIMEOUT_EN defined, a gap of TIMEOUT_CLKS cycles with no i_rx_dv in GET_ADDR or GET_DATA SHALL abandon the frame, pulse o_err, send nothing and return to IDLE.
REQ-025 Without UART_SPI_BRIDGE_TIMEOUT_EN, there SHALL be no timeout counter and partial frames SHALL wait indefinitely.

Structure
REQ-026 Opcode, ACK and NAK constants and the state encoding SHALL live in package uart_spi_bridge_pkg.
REQ-027 SPI serialisation SHALL be a sub-module spi_shift_master (params WIDTH, SCLK_DIV; start/done handshake; parallel in/out).

Verification (ADDR_W=8, DATA_W=8, SCLK_DIV=2)
REQ-028 Write: RX 0x57,0xF8,0xA5 -> cs_n low for 16 SCLK cycles, MOSI 0xF8A5; then o_tx_byte=0x06 once.
REQ-029 Read: RX 0x52,0xF8 with MISO model returning 0x3C in the data field -> MOSI 0xF800; o_tx_byte=0x3C.
REQ-030 Bad opcode: RX 0x41 -> o_tx_byte=0x15, o_err pulse, no cs_n activity.
REQ-031 Backpressure: hold i_tx_active high for 1000 cycles during the response -> o_tx_dv is not asserted until it falls; then exactly one pulse.
REQ-032 Reset mid-SPI: assert i_reset after 5 SCLK edges -> next cycle cs_n=1, sclk=0, o_busy=0; a subsequent write frame completes normally.
REQ-033 Timeout (macro on, TIMEOUT_CLKS=100): RX 0x57 only, then idle 100 cycles -> o_err pulse, no TX, IDLE; macro off -> still GET_ADDR.

Source files
------------

// File: rtl/uart_spi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_spi_bridge_pkg
// Summary  : Shared constants, state encodings and helpers for the UART to
//            SPI register bridge.
// Revision : 1.0 - initial release
// ============================================================================
package uart_spi_bridge_pkg;

    // Frame opcodes and response codes
    localparam logic [7:0] C_OP_WRITE = 8'h57;
    localparam logic [7:0] C_OP_READ  = 8'h52;
    localparam logic [7:0] C_ACK      = 8'h06;
    localparam logic [7:0] C_NAK      = 8'h15;

    // Bridge frame-level states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_SPI_RUN   = 3'd3,
        ST_SEND_RESP = 3'd4
    } state_t;

    // SPI shifter phases
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_LEAD  = 3'd1,
        PH_HIGH  = 3'd2,
        PH_LOW   = 3'd3,
        PH_TRAIL = 3'd4
    } spi_phase_t;

    // Number of UART bytes needed to carry a field of the given bit width
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_shift_master
// Summary  : Mode-0 SPI master shifting one WIDTH-bit word MSB first. A start
//            pulse launches the transfer; done pulses once cs_n is released.
// Revision : 1.0 - initial release
// ============================================================================
module spi_shift_master
    import uart_spi_bridge_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SCLK_DIV = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_tx_word,
    input  logic             i_miso,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rx_word,
    output logic             o_cs_n,
    output logic             o_sclk,
    output logic             o_mosi
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(WIDTH - 1);

    spi_phase_t       r_phase;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rx;
    logic             r_done;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_mosi;

    logic             w_half_done;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_rx_next;

    assign w_half_done  = (r_div == C_DIV_LAST);
    assign w_shift_next = r_shift << 1;
    assign w_rx_next    = (r_rx << 1) | WIDTH'(i_miso);

    // Half-period sequencer: lead-in, WIDTH high/low pairs, trailing hold
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_phase <= PH_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rx    <= '0;
            r_done  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (i_start) begin
                        r_cs_n  <= 1'b0;
                        r_shift <= i_tx_word;
                        r_mosi  <= i_tx_word[WIDTH-1];
                        r_rx    <= '0;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_phase <= PH_LEAD;
                    end
                end
                PH_LEAD, PH_LOW: begin
                    if (w_half_done) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx    <= w_rx_next;
                        r_phase <= PH_HIGH;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (w_half_done) begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit == C_BIT_LAST) begin
                            r_phase <= PH_TRAIL;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_next;
                            r_mosi  <= w_shift_next[WIDTH-1];
                            r_phase <= PH_LOW;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                PH_TRAIL: begin
                    if (w_half_done) begin
                        r_div   <= '0;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_phase <= PH_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign o_done    = r_done;
    assign o_rx_word = r_rx;
    assign o_cs_n    = r_cs_n;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;

endmodule
`default_nettype wire

// File: rtl/uart_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_spi_bridge
// Summary  : Parses opcode/address/data frames from a byte-wide UART receiver,
//            runs one SPI transaction and answers over the UART transmitter.
// Config   : define UART_SPI_BRIDGE_TIMEOUT_EN to abandon partial frames after
//            TIMEOUT_CLKS idle cycles; otherwise partial frames wait forever.
// Revision : 1.0 - initial release
// ============================================================================
module uart_spi_bridge
    import uart_spi_bridge_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int SCLK_DIV     = 4,
    parameter int TIMEOUT_CLKS = 500000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    output logic       o_spi_cs_n,
    output logic       o_spi_sclk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_busy,
    output logic       o_err
);

    localparam int C_ADDR_BYTES = bytes_for(ADDR_W);
    localparam int C_DATA_BYTES = bytes_for(DATA_W);
    localparam int C_ADDR_ACC_W = C_ADDR_BYTES * 8;
    localparam int C_DATA_ACC_W = C_DATA_BYTES * 8;
    localparam int C_SPI_W      = ADDR_W + DATA_W;
    localparam logic [1:0] C_ADDR_LAST = 2'(C_ADDR_BYTES - 1);
    localparam logic [1:0] C_DATA_LAST = 2'(C_DATA_BYTES - 1);
    localparam logic [1:0] C_DATA_CNT  = 2'(C_DATA_BYTES);

    state_t                  r_state;
    logic                    r_is_write;
    logic [1:0]              r_byte_cnt;
    logic [C_ADDR_ACC_W-1:0] r_addr_acc;
    logic [C_DATA_ACC_W-1:0] r_data_acc;
    logic                    r_spi_start;
    logic [C_DATA_ACC_W-1:0] r_resp_shift;
    logic [1:0]              r_resp_left;
    logic                    r_tx_skip;
    logic                    r_tx_dv;
    logic [7:0]              r_tx_byte;
    logic                    r_err;

    logic [C_SPI_W-1:0]      w_spi_tx;
    logic [C_SPI_W-1:0]      w_spi_rx;
    logic                    w_spi_done;
    logic                    w_timeout;
    logic                    w_unused_rx_addr;

    // Address always leads; the data field of a read is shifted out as zeros
    assign w_spi_tx = {r_addr_acc[ADDR_W-1:0],
                       (r_is_write ? r_data_acc[DATA_W-1:0] : {DATA_W{1'b0}})};

    // Bits clocked in during the address phase carry no information
    assign w_unused_rx_addr = &{1'b0, w_spi_rx[C_SPI_W-1:DATA_W]};

`ifdef UART_SPI_BRIDGE_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CLKS - 1);

    logic [C_TO_W-1:0] r_to_cnt;
    logic              w_collecting;

    assign w_collecting = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
    assign w_timeout    = w_collecting && !i_rx_dv && (r_to_cnt == C_TO_LAST);

    // Inter-byte gap counter, restarted by every received byte
    always_ff @(posedge i_clock) begin
        if (i_reset || !w_collecting || i_rx_dv || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Frame parser, SPI launch and paced response transmitter
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_is_write   <= 1'b0;
            r_byte_cnt   <= '0;
            r_addr_acc   <= '0;
            r_data_acc   <= '0;
            r_spi_start  <= 1'b0;
            r_resp_shift <= '0;
            r_resp_left  <= '0;
            r_tx_skip    <= 1'b0;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_tx_dv     <= 1'b0;
            r_err       <= 1'b0;
            r_spi_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_dv) begin
                        r_byte_cnt <= '0;
                        r_addr_acc <= '0;
                        r_data_acc <= '0;
                        if (i_rx_byte == C_OP_WRITE) begin
                            r_is_write <= 1'b1;
                            r_state    <= ST_GET_ADDR;
                        end else if (i_rx_byte == C_OP_READ) begin
                            r_is_write <= 1'b0;
                            r_state    <= ST_GET_ADDR;
                        end else begin
                            // NAK goes through the paced sender to honour backpressure
                            r_err        <= 1'b1;
                            r_resp_shift <= C_DATA_ACC_W'(C_NAK) << (C_DATA_ACC_W - 8);
                            r_resp_left  <= 2'd1;
                            r_tx_skip    <= 1'b0;
                            r_state      <= ST_SEND_RESP;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (i_rx_dv) begin
                        r_addr_acc <= (r_addr_acc << 8) | C_ADDR_ACC_W'(i_rx_byte);
                        if (r_byte_cnt == C_ADDR_LAST) begin
                            r_byte_cnt <= '0;
                            if (r_is_write) begin
                                r_state <= ST_GET_DATA;
                            end else begin
                                r_spi_start <= 1'b1;
                                r_state     <= ST_SPI_RUN;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (i_rx_dv) begin
                        r_data_acc <= (r_data_acc << 8) | C_DATA_ACC_W'(i_rx_byte);
                        if (r_byte_cnt == C_DATA_LAST) begin
                            r_byte_cnt  <= '0;
                            r_spi_start <= 1'b1;
                            r_state     <= ST_SPI_RUN;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_SPI_RUN: begin
                    if (i_rx_dv) begin
                        r_err <= 1'b1;
                    end
                    if (w_spi_done) begin
                        if (r_is_write) begin
                            r_resp_shift <= C_DATA_ACC_W'(C_ACK) << (C_DATA_ACC_W - 8);
                            r_resp_left  <= 2'd1;
                        end else begin
                            r_resp_shift <= C_DATA_ACC_W'(w_spi_rx[DATA_W-1:0]);
                            r_resp_left  <= C_DATA_CNT;
                        end
                        r_tx_skip <= 1'b0;
                        r_state   <= ST_SEND_RESP;
                    end
                end
                ST_SEND_RESP: begin
                    if (i_rx_dv) begin
                        r_err <= 1'b1;
                    end
                    if (r_tx_skip) begin
                        // Give the transmitter a cycle to raise its busy flag
                        r_tx_skip <= 1'b0;
                        if (r_resp_left == 2'd0) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (!i_tx_active) begin
                        r_tx_dv      <= 1'b1;
                        r_tx_byte    <= r_resp_shift[C_DATA_ACC_W-1 -: 8];
                        r_resp_shift <= r_resp_shift << 8;
                        r_resp_left  <= r_resp_left - 1'b1;
                        r_tx_skip    <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    spi_shift_master #(
        .WIDTH    (C_SPI_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_start   (r_spi_start),
        .i_tx_word (w_spi_tx),
        .i_miso    (i_spi_miso),
        .o_done    (w_spi_done),
        .o_rx_word (w_spi_rx),
        .o_cs_n    (o_spi_cs_n),
        .o_sclk    (o_spi_sclk),
        .o_mosi    (o_spi_mosi)
    );

    assign o_tx_dv   = r_tx_dv;
    assign o_tx_byte = r_tx_byte;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_err     = r_err;

endmodule
`default_nettype wire
